// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/gnt/rvalid data-memory port and holds the MEM/WB register.
// Define MEM_ALIGN_CHECK_EN to make word-misaligned accesses complete with a misalign pulse instead of a bus request.
module mem_access_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic [31:0] PCIn,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] STValIn,
    input  logic [4:0]  destIn,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic [31:0] PC,
    output logic [31:0] ALURes,
    output logic [31:0] MemData,
    output logic [4:0]  dest,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, RWAIT, CMPL} state_t;

    localparam int            CW      = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   ld_buf;
    logic          access;
    logic          is_wr;
    logic          timeout;
    logic          mis_det;

    assign access  = MEM_R_EN_IN | MEM_W_EN_IN;
    assign is_wr   = MEM_W_EN_IN;
    assign timeout = ((state == REQ) || (state == RWAIT)) && (wait_cnt == MAX_CNT);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_det = |ALUResIn[1:0];
`else
    assign mis_det = 1'b0;
`endif

    assign dmem_addr  = ALUResIn;
    assign dmem_wdata = STValIn;

    always_ff @(posedge clk) begin
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    // Timeout wins over a same-cycle gnt/rvalid so a late response never extends the access.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access) state_nxt = mis_det ? CMPL : REQ;
            end
            REQ: begin
                if (timeout)       state_nxt = CMPL;
                else if (dmem_gnt) state_nxt = is_wr ? CMPL : RWAIT;
            end
            RWAIT: begin
                if (timeout || dmem_rvalid) state_nxt = CMPL;
            end
            CMPL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        dmem_req = 1'b0;
        if (!rstn) begin
            case (state)
                IDLE:    stall = access;
                REQ:     begin stall = 1'b1; dmem_req = 1'b1; end
                RWAIT:   stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
        dmem_we = dmem_req & is_wr;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wait_cnt <= '0;
            ld_buf   <= '0;
            bus_err  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (state == IDLE)
                wait_cnt <= '0;
            else if ((state == REQ) || (state == RWAIT))
                wait_cnt <= wait_cnt + CW'(1);
            if ((state == RWAIT) && dmem_rvalid)
                ld_buf <= dmem_rdata;
            bus_err  <= timeout;
            misalign <= (state == IDLE) && access && mis_det;
        end
    end

    // MEM/WB boundary: bubble while stalled; error flags are high only during CMPL.
    always_ff @(posedge clk) begin
        if (rstn) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            PC       <= '0;
            ALURes   <= '0;
            MemData  <= '0;
            dest     <= '0;
        end else if (stall) begin
            WB_EN <= 1'b0;
        end else begin
            WB_EN    <= WB_EN_IN & ~(bus_err | misalign);
            MEM_R_EN <= MEM_R_EN_IN;
            PC       <= PCIn;
            ALURes   <= ALUResIn;
            dest     <= destIn;
            MemData  <= ((state == CMPL) && !is_wr && !bus_err && !misalign) ? ld_buf : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load, store, timeout, reset abort, alignment.
module tb_mem_access_stage;

    logic        clk;
    logic        rstn;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [31:0] PCIn, ALUResIn, STValIn;
    logic [4:0]  destIn;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        WB_EN, MEM_R_EN;
    logic [31:0] PC, ALURes, MemData;
    logic [4:0]  dest;
    logic        bus_err, misalign;

    int n_chk  = 0;
    int n_fail = 0;
    int n_cyc;

    mem_access_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .rstn(rstn),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .PCIn(PCIn), .ALUResIn(ALUResIn), .STValIn(STValIn), .destIn(destIn),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .PC(PC), .ALURes(ALURes),
        .MemData(MemData), .dest(dest), .bus_err(bus_err), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        WB_EN_IN = 0; MEM_R_EN_IN = 0; MEM_W_EN_IN = 0;
        PCIn = 0; ALUResIn = 0; STValIn = 0; destIn = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        clear_inputs();
        step();
        step();
        check("rst_wb_en",   32'(WB_EN),    32'h0);
        check("rst_memdata", MemData,       32'h0);
        check("rst_dest",    32'(dest),     32'h0);
        check("rst_bus_err", 32'(bus_err),  32'h0);
        MEM_R_EN_IN = 1;
        #1;
        check("rst_stall_gated", 32'(stall),    32'h0);
        check("rst_req_gated",   32'(dmem_req), 32'h0);
        MEM_R_EN_IN = 0;
        step();
        rstn = 1'b0;

        // ALU op passes straight through
        WB_EN_IN = 1; destIn = 5; ALUResIn = 32'h10; PCIn = 32'h40;
        #1;
        check("alu_stall", 32'(stall), 32'h0);
        step();
        check("alu_stall2", 32'(stall),  32'h0);
        check("alu_wb_en",  32'(WB_EN),  32'h1);
        check("alu_dest",   32'(dest),   32'h5);
        check("alu_res",    ALURes,      32'h10);
        check("alu_pc",     PC,          32'h40);
        check("alu_memdata", MemData,    32'h0);

        // Load at 0x100, gnt in first REQ cycle, rvalid one cycle later
        MEM_R_EN_IN = 1; destIn = 7; ALUResIn = 32'h100; PCIn = 32'h44;
        #1;
        check("ld_stall_idle", 32'(stall),    32'h1);
        check("ld_req_idle",   32'(dmem_req), 32'h0);
        step();
        check("ld_bubble",    32'(WB_EN), 32'h0);
        check("ld_dest_hold", 32'(dest),  32'h5);
        check("ld_res_hold",  ALURes,     32'h10);
        dmem_gnt = 1;
        #1;
        check("ld_req",    32'(dmem_req), 32'h1);
        check("ld_we",     32'(dmem_we),  32'h0);
        check("ld_addr",   dmem_addr,     32'h100);
        check("ld_stall_req", 32'(stall), 32'h1);
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_stall_rwait", 32'(stall),    32'h1);
        check("ld_req_rwait",   32'(dmem_req), 32'h0);
        check("ld_we_rwait",    32'(dmem_we),  32'h0);
        step();
        dmem_rvalid = 0; dmem_rdata = 0;
        #1;
        check("ld_stall_cmpl", 32'(stall), 32'h0);
        step();
        clear_inputs();
        check("ld_memdata", MemData,       32'hDEADBEEF);
        check("ld_mem_r_en", 32'(MEM_R_EN), 32'h1);
        check("ld_wb_en",   32'(WB_EN),    32'h1);
        check("ld_dest",    32'(dest),     32'h7);
        check("ld_pc",      PC,            32'h44);

        // Store at 0x200 with read also set (write wins), gnt delayed two cycles
        MEM_W_EN_IN = 1; MEM_R_EN_IN = 1; ALUResIn = 32'h200; STValIn = 32'hCAFEF00D; PCIn = 32'h48;
        #1;
        check("st_stall_idle", 32'(stall),   32'h1);
        check("st_we_idle",    32'(dmem_we), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            dmem_gnt = (i == 2);
            #1;
            check("st_req",   32'(dmem_req), 32'h1);
            check("st_we",    32'(dmem_we),  32'h1);
            check("st_addr",  dmem_addr,     32'h200);
            check("st_wdata", dmem_wdata,    32'hCAFEF00D);
        end
        step();
        dmem_gnt = 0;
        #1;
        check("st_req_cmpl",   32'(dmem_req), 32'h0);
        check("st_stall_cmpl", 32'(stall),    32'h0);
        step();
        clear_inputs();
        check("st_memdata",  MemData,        32'h0);
        check("st_mem_r_en", 32'(MEM_R_EN),  32'h1);
        check("st_pc",       PC,             32'h48);
        check("st_wb_en",    32'(WB_EN),     32'h0);

        // Load whose rvalid never comes: timeout after the wait budget
        MEM_R_EN_IN = 1; WB_EN_IN = 1; destIn = 9; ALUResIn = 32'h300; PCIn = 32'h4C;
        #1;
        n_cyc = 0;
        while (stall && n_cyc < 40) begin
            @(posedge clk);
            #1;
            n_cyc++;
            dmem_gnt = (n_cyc == 1);
            #1;
        end
        check("to_stall_cycles", 32'(n_cyc),   32'd17);
        check("to_bus_err",      32'(bus_err), 32'h1);
        check("to_stall_cmpl",   32'(stall),   32'h0);
        dmem_rvalid = 1; dmem_rdata = 32'hBADBAD00;
        step();
        clear_inputs();
        check("to_bus_err_clr", 32'(bus_err), 32'h0);
        check("to_wb_en",       32'(WB_EN),   32'h0);
        check("to_memdata",     MemData,      32'h0);
        check("to_dest",        32'(dest),    32'h9);

        // Reset while waiting for read data; late rvalid must be ignored
        MEM_R_EN_IN = 1; WB_EN_IN = 1; destIn = 3; ALUResIn = 32'h400; PCIn = 32'h50;
        step();
        dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        rstn = 1;
        #1;
        check("rr_stall_in_rst", 32'(stall),    32'h0);
        check("rr_req_in_rst",   32'(dmem_req), 32'h0);
        step();
        rstn = 0;
        MEM_R_EN_IN = 0; WB_EN_IN = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        #1;
        check("rr_wb_en",  32'(WB_EN),    32'h0);
        check("rr_dest",   32'(dest),     32'h0);
        check("rr_pc",     PC,            32'h0);
        check("rr_alures", ALURes,        32'h0);
        check("rr_mem_r",  32'(MEM_R_EN), 32'h0);
        check("rr_stall",  32'(stall),    32'h0);
        step();
        dmem_rvalid = 0;
        #1;
        check("rr_stall_after", 32'(stall), 32'h0);
        check("rr_memdata",     MemData,    32'h0);
        clear_inputs();

        // rvalid during REQ and gnt during RWAIT are ignored
        MEM_R_EN_IN = 1; WB_EN_IN = 1; destIn = 11; ALUResIn = 32'h500; PCIn = 32'h54;
        step();
        dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h11111111;
        step();
        dmem_rvalid = 0;
        #1;
        check("ign_stall_rwait", 32'(stall), 32'h1);
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h22222222;
        step();
        dmem_rvalid = 0;
        step();
        clear_inputs();
        check("ign_memdata", MemData,    32'h22222222);
        check("ign_dest",    32'(dest),  32'd11);
        check("ign_wb_en",   32'(WB_EN), 32'h1);

`ifdef MEM_ALIGN_CHECK_EN
        MEM_R_EN_IN = 1; WB_EN_IN = 1; destIn = 4; ALUResIn = 32'h102;
        #1;
        check("mis_stall_idle", 32'(stall),    32'h1);
        check("mis_req_idle",   32'(dmem_req), 32'h0);
        step();
        check("mis_req_cmpl", 32'(dmem_req), 32'h0);
        check("mis_pulse",    32'(misalign), 32'h1);
        check("mis_stall",    32'(stall),    32'h0);
        step();
        clear_inputs();
        check("mis_pulse_clr", 32'(misalign), 32'h0);
        check("mis_wb_en",     32'(WB_EN),    32'h0);
`else
        MEM_R_EN_IN = 1; WB_EN_IN = 1; destIn = 4; ALUResIn = 32'h102;
        step();
        check("ua_req",   32'(dmem_req), 32'h1);
        check("ua_addr",  dmem_addr,     32'h102);
        check("ua_misal", 32'(misalign), 32'h0);
        dmem_gnt = 1;
        step();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h0BADF00D;
        step();
        dmem_rvalid = 0;
        step();
        clear_inputs();
        check("ua_memdata", MemData,       32'h0BADF00D);
        check("ua_misal2",  32'(misalign), 32'h0);
        check("ua_wb_en",   32'(WB_EN),    32'h1);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the cycles allowed in REQ+RWAIT before a bus timeout.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  SHALL be the synchronous, active-high reset.
REQ-004 WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  input  1 each  SHALL be the EX/MEM control bits.
REQ-005 PCIn, ALUResIn, STValIn  input  32 each  SHALL be the EX/MEM PC, ALU result/address and store data.
REQ-006 destIn  input  5  SHALL be the EX/MEM destination register.
REQ-007 stall  output  1  SHALL freeze the EX/MEM register and upstream stages when high.
REQ-008 dmem_req, dmem_we  output  1 each  SHALL be the data-memory request and write-enable.
REQ-009 dmem_addr, dmem_wdata  output  32 each  SHALL carry ALUResIn and STValIn.
REQ-010 dmem_gnt, dmem_rvalid  input  1 each  SHALL be request accept and read-data valid.
REQ-011 dmem_rdata  input  32  SHALL be the read data.
REQ-012 WB_EN, MEM_R_EN  output  1 each  SHALL be the registered MEM/WB control bits.
REQ-013 PC, ALURes, MemData  output  32 each  SHALL be the registered MEM/WB PC, ALU result and load data.
REQ-014 dest  output  5  SHALL be the registered MEM/WB destination.
REQ-015 bus_err, misalign  output  1 each  SHALL be one-cycle registered error pulses.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RWAIT and CMPL.
REQ-017 IDLE, no access: stall=0; MEM/WB registers load inputs next edge (latency 1); MemData loads 0.
REQ-018 IDLE with MEM_R_EN_IN or MEM_W_EN_IN: stall=1 combinationally, next state REQ.
REQ-019 REQ: dmem_req=1, stall=1; dmem_gnt with write -> CMPL; dmem_gnt with read -> RWAIT.
REQ-020 RWAIT: dmem_req=0, stall=1; on dmem_rvalid, capture dmem_rdata into the load buffer -> CMPL.
REQ-021 CMPL: stall=0; MEM/WB registers load inputs, MemData loads the buffer (0 for writes); next state IDLE.
REQ-022 While stall=1, WB_EN SHALL load 0 (bubble); other MEM/WB outputs hold.
REQ-023 MEM_R_EN_IN and MEM_W_EN_IN both high SHALL be a write (write priority).
REQ-024 dmem_we, dmem_addr and dmem_wdata SHALL be valid whenever dmem_req=1; dmem_we=0 otherwise.
REQ-025 dmem_rvalid outside RWAIT and dmem_gnt outside REQ SHALL be ignored.
REQ-026 A wait counter SHALL clear on REQ entry and increment each REQ/RWAIT cycle.
REQ-027 At count == MAX_WAIT: go to CMPL, pulse bus_err, force WB_EN=0 and MemData=0 for that instruction.
REQ-028 Minimum latency: write 3 cycles (IDLE, REQ, CMPL); read 4 cycles (IDLE, REQ, RWAIT, CMPL).

Reset
REQ-029 rstn high at an edge SHALL set state IDLE, the counter and load buffer to 0, and every registered output to 0.
REQ-030 While rstn is high, stall and dmem_req SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon it; late dmem_gnt/dmem_rvalid SHALL be ignored.

Configuration
REQ-032 With MEM_ALIGN_CHECK_EN defined, an IDLE access with ALUResIn[1:0] != 0 SHALL skip REQ and go directly to CMPL; dmem_req never asserts; misalign pulses; WB_EN is 0.
REQ-033 Without MEM_ALIGN_CHECK_EN, misalign SHALL be tied 0 and dmem_addr SHALL carry the full 32-bit address unmodified.

Verification
REQ-034 ALU op WB_EN_IN=1, destIn=5, ALUResIn=0x10 -> next cycle WB_EN=1, dest=5, ALURes=0x10, stall never high.
REQ-035 Load at 0x100, dmem_gnt in the first REQ cycle, dmem_rvalid with 0xDEADBEEF one cycle later -> stall high 3 cycles, then MemData=0xDEADBEEF, MEM_R_EN=1.
REQ-036 Store at 0x200 with STValIn=0xCAFEF00D, dmem_gnt delayed 2 cycles -> dmem_req held 3 cycles with dmem_we=1 and stable addr/data, then CMPL.
REQ-037 Load with dmem_rvalid never asserted -> bus_err pulses after 15 wait cycles, WB_EN=0, stall drops.
REQ-038 rstn asserted in RWAIT, dmem_rvalid arriving next cycle -> outputs 0, state IDLE, data ignored.
REQ-039 With MEM_ALIGN_CHECK_EN defined, load at 0x102 -> no dmem_req, misalign pulses, WB_EN=0.
